// File: rtl/clk_div_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : clk_div_sel_ctrl
// Description: Glitch-free selector for a /2,/4,/8 divider chain with a
//              req/ack ratio-change handshake applied at the common wrap.
// Revision   : 1.0 - initial release
// ============================================================================
module clk_div_sel_ctrl #(
   parameter logic [1:0] DEFAULT_SEL = 2'd0
) (
   input  logic       clk_in,
   input  logic       rst,
   input  logic       req,
   input  logic [1:0] sel_req,
   output logic       busy,
   output logic       ack,
   output logic       err,
   output logic [1:0] sel_cur,
   output logic       clk_out,
   output logic       clk_out2,
   output logic       clk_out4,
   output logic       clk_out8
);

   typedef enum logic [0:0] {
      IDLE      = 1'b0,
      WAIT_WRAP = 1'b1
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [2:0] r_cnt;
   logic [2:0] w_cnt_nxt;
   logic [1:0] r_sel_cur;
   logic [1:0] w_sel_cur_nxt;
   logic [1:0] r_sel_pend;
   logic [1:0] w_sel_pend_nxt;
   logic [1:0] w_sel_next;
   logic       r_ack;
   logic       w_ack_nxt;
   logic       r_ack_dfr;
   logic       w_ack_dfr_nxt;
   logic       r_err;
   logic       w_err_nxt;
   logic       r_clk_out;
   logic       w_clk_out_nxt;
   logic       w_switch;

   function automatic logic tap(input logic [1:0] sel, input logic [2:0] c);
      case (sel)
         2'd0:    tap = c[0];
         2'd1:    tap = c[1];
         2'd2:    tap = c[2];
         default: tap = 1'b0;
      endcase
   endfunction

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_cnt      <= 3'd0;
         r_sel_cur  <= DEFAULT_SEL;
         r_sel_pend <= 2'd0;
         r_ack      <= 1'b0;
         r_ack_dfr  <= 1'b0;
         r_err      <= 1'b0;
         r_clk_out  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_sel_cur  <= w_sel_cur_nxt;
         r_sel_pend <= w_sel_pend_nxt;
         r_ack      <= w_ack_nxt;
         r_ack_dfr  <= w_ack_dfr_nxt;
         r_err      <= w_err_nxt;
         r_clk_out  <= w_clk_out_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt + 3'd1;
      w_sel_cur_nxt  = r_sel_cur;
      w_sel_pend_nxt = r_sel_pend;
      w_ack_nxt      = r_ack_dfr;
      w_ack_dfr_nxt  = 1'b0;
      w_err_nxt      = 1'b0;
      w_switch       = 1'b0;

      case (r_state)
         IDLE: begin
            if (req) begin
               if (sel_req == r_sel_cur) begin
                  w_ack_nxt = 1'b1;
               end else begin
                  w_sel_pend_nxt = sel_req;
                  w_state_nxt    = WAIT_WRAP;
               end
            end
         end
         WAIT_WRAP: begin
            if (req) begin
               w_err_nxt = 1'b1;
            end
            if (r_cnt == 3'd7) begin
               w_switch      = 1'b1;
               w_sel_cur_nxt = r_sel_pend;
               w_state_nxt   = IDLE;
               // A collision on the switch edge owns this cycle's pulse, so
               // the completion ack is pushed one cycle later.
               if (req) begin
                  w_ack_dfr_nxt = 1'b1;
               end else begin
                  w_ack_nxt = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      w_sel_next    = w_switch ? r_sel_pend : r_sel_cur;
      w_clk_out_nxt = tap(w_sel_next, w_cnt_nxt);
   end

   assign busy     = (r_state == WAIT_WRAP);
   assign ack      = r_ack;
   assign err      = r_err;
   assign sel_cur  = r_sel_cur;
   assign clk_out  = r_clk_out;
   assign clk_out2 = r_cnt[0];
   assign clk_out4 = r_cnt[1];
   assign clk_out8 = r_cnt[2];

endmodule
`default_nettype wire

// File: tb/tb_clk_div_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : tb_clk_div_sel_ctrl
// Description: Directed plus random checks of clk_div_sel_ctrl against a
//              cycle-count based reference model.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_clk_div_sel_ctrl;

   localparam logic [1:0] DEF_SEL = 2'd0;

   logic       clk_in;
   logic       rst;
   logic       req;
   logic [1:0] sel_req;
   logic       busy;
   logic       ack;
   logic       err;
   logic [1:0] sel_cur;
   logic       clk_out;
   logic       clk_out2;
   logic       clk_out4;
   logic       clk_out8;

   int total = 0;
   int bad   = 0;

   // Reference model: edges since reset, selected ratio, pending change
   int         m_t;
   logic [1:0] m_sel;
   logic [1:0] m_pend;
   logic       m_busy;
   int         m_left;
   logic       m_ack_dfr;
   logic       e_ack;
   logic       e_err;

   clk_div_sel_ctrl #(.DEFAULT_SEL(DEF_SEL)) dut (
      .clk_in   (clk_in),
      .rst      (rst),
      .req      (req),
      .sel_req  (sel_req),
      .busy     (busy),
      .ack      (ack),
      .err      (err),
      .sel_cur  (sel_cur),
      .clk_out  (clk_out),
      .clk_out2 (clk_out2),
      .clk_out4 (clk_out4),
      .clk_out8 (clk_out8)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_t       = 0;
      m_sel     = DEF_SEL;
      m_pend    = 2'd0;
      m_busy    = 1'b0;
      m_left    = 0;
      m_ack_dfr = 1'b0;
      e_ack     = 1'b0;
      e_err     = 1'b0;
   endtask

   // One rising edge of the reference model with the sampled request
   task automatic model_edge(input logic r, input logic [1:0] s);
      int c;
      c         = m_t % 8;
      e_err     = 1'b0;
      e_ack     = m_ack_dfr;
      m_ack_dfr = 1'b0;
      if (!m_busy) begin
         if (r) begin
            if (s == m_sel) begin
               e_ack = 1'b1;
            end else begin
               m_pend = s;
               m_busy = 1'b1;
               m_left = ((14 - c) % 8) + 1;
            end
         end
      end else begin
         m_left--;
         if (r) e_err = 1'b1;
         if (m_left == 0) begin
            m_sel  = m_pend;
            m_busy = 1'b0;
            if (r) m_ack_dfr = 1'b1;
            else   e_ack     = 1'b1;
         end
      end
      m_t++;
   endtask

   task automatic chk_all();
      int per;
      logic exp_out;
      per     = 2 << m_sel;
      exp_out = (m_sel == 2'd3) ? 1'b0 : ((m_t % per) >= (per / 2));
      chk("clk_out2", 2'(clk_out2), 2'((m_t / 1) % 2));
      chk("clk_out4", 2'(clk_out4), 2'((m_t / 2) % 2));
      chk("clk_out8", 2'(clk_out8), 2'((m_t / 4) % 2));
      chk("clk_out",  2'(clk_out),  2'(exp_out));
      chk("sel_cur",  sel_cur,      m_sel);
      chk("busy",     2'(busy),     2'(m_busy));
      chk("ack",      2'(ack),      2'(e_ack));
      chk("err",      2'(err),      2'(e_err));
   endtask

   task automatic cyc(input logic r, input logic [1:0] s);
      req     = r;
      sel_req = s;
      @(posedge clk_in);
      model_edge(r, s);
      #1;
      chk_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 2'd0);
   endtask

   task automatic run_to(input int target);
      for (int i = 0; i < 8; i++) begin
         if ((m_t % 8) != target) cyc(1'b0, 2'd0);
      end
   endtask

   initial begin
      rst     = 1'b0;
      req     = 1'b0;
      sel_req = 2'd0;
      model_reset();

      // Reset state
      @(posedge clk_in);
      #1;
      chk_all();
      #2;
      rst = 1'b1;

      // Free-running /2 after release
      idle(16);

      // Change to /8 accepted at cnt=2
      run_to(2);
      cyc(1'b1, 2'd2);
      idle(12);

      // Back to /4, then /8 accepted at cnt=7
      run_to(0);
      cyc(1'b1, 2'd1);
      idle(10);
      run_to(7);
      cyc(1'b1, 2'd2);
      idle(10);

      // Same-select request while on /4, including a held req
      run_to(1);
      cyc(1'b1, 2'd1);
      idle(10);
      cyc(1'b1, 2'd1);
      idle(2);
      cyc(1'b1, 2'd1);
      cyc(1'b1, 2'd1);
      cyc(1'b1, 2'd1);
      idle(4);

      // Collision while waiting to switch off
      run_to(3);
      cyc(1'b1, 2'd3);
      cyc(1'b1, 2'd1);
      idle(12);

      // Collision on the switch edge itself, leaving off
      cyc(1'b1, 2'd0);
      for (int i = 0; i < 10; i++) begin
         if (m_busy && m_left > 1) cyc(1'b0, 2'd0);
      end
      cyc(1'b1, 2'd2);
      idle(12);

      // Asynchronous reset while a change is pending at cnt=4
      run_to(3);
      cyc(1'b1, 2'd2);
      rst = 1'b0;
      #1;
      model_reset();
      chk_all();
      #2;
      rst = 1'b1;
      idle(12);

      // Random requests
      for (int i = 0; i < 400; i++) begin
         cyc($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
